// File: rtl/dds_sweep_ctrl.sv
// N-channel DDS tuning-word sweep generator (hold / saw / triangle / single-shot).
// Latency: control and config inputs take effect one clock after they are sampled.
// Backpressure: none; strobes are single-cycle and every output is registered.
//
// Ports:
//   clk, reset        DDS-domain clock, synchronous active-low reset
//   cfg_we/ch/sel/data  per-channel config write (0 f_min, 1 f_max, 2 f_step, 3 dwell, 4 mode)
//   start, stop, sync   per-channel start/stop pulses, global phase-coherent restart
//   freq, active, done  per-channel tuning word, running flag, single-shot completion pulse
//   cfg_err             pulse when a start is rejected because f_min > f_max
module dds_sweep_ctrl #(
   parameter int CH = 4,
   parameter int FW = 32,
   parameter int DW = 16
) (
   input  logic                                clk,
   input  logic                                reset,
   input  logic                                cfg_we,
   input  logic [((CH > 1) ? $clog2(CH) : 1)-1:0] cfg_ch,
   input  logic [2:0]                          cfg_sel,
   input  logic [FW-1:0]                       cfg_data,
   input  logic [CH-1:0]                       start,
   input  logic [CH-1:0]                       stop,
   input  logic                                sync,
   output logic [CH*FW-1:0]                    freq,
   output logic [CH-1:0]                       active,
   output logic [CH-1:0]                       done,
   output logic                                cfg_err
);

   localparam int CW = (CH > 1) ? $clog2(CH) : 1;
   // One extra bit so CH itself is representable when bounding cfg_ch.
   localparam logic [CW:0] CH_L = (CW+1)'(CH);

   localparam logic [1:0] M_HOLD = 2'd0;
   localparam logic [1:0] M_SAW  = 2'd1;
   localparam logic [1:0] M_TRI  = 2'd2;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      UP   = 2'd1,
      DOWN = 2'd2
   } state_t;

   logic          cfg_hit;
   logic [CH-1:0] err_req;

   assign cfg_hit = cfg_we && ({1'b0, cfg_ch} < CH_L);

   for (genvar k = 0; k < CH; k++) begin : g_ch
      logic [FW-1:0] f_min, f_max, f_step;
      logic [DW-1:0] dwell;
      logic [1:0]    mode;
      logic          wr;

      state_t        st_r, st_n;
      logic [FW-1:0] freq_r, freq_n;
      logic [DW-1:0] cnt_r, cnt_n;
      logic          done_r, done_n;

      logic [FW:0]   nxt_up, nxt_dn;
      logic          over, under, run, step_ev, bad_cfg;

      assign wr = cfg_hit && (cfg_ch == CW'(k));

      always_ff @(posedge clk) begin
         if (!reset) begin
            f_min  <= '0;
            f_max  <= '1;
            f_step <= FW'(1);
            dwell  <= '0;
            mode   <= M_HOLD;
         end else if (wr) begin
            case (cfg_sel)
               3'd0:    f_min  <= cfg_data;
               3'd1:    f_max  <= cfg_data;
               3'd2:    f_step <= cfg_data;
               3'd3:    dwell  <= cfg_data[DW-1:0];
               3'd4:    mode   <= cfg_data[1:0];
               default: ;
            endcase
         end
      end

      // FW+1 bit arithmetic: the top bit is the carry (up) or borrow (down).
      assign nxt_up  = {1'b0, freq_r} + {1'b0, f_step};
      assign nxt_dn  = {1'b0, freq_r} - {1'b0, f_step};
      assign over    = nxt_up[FW] || (nxt_up[FW-1:0] > f_max);
      assign under   = nxt_dn[FW] || (nxt_dn[FW-1:0] < f_min);
      assign run     = (st_r != IDLE);
      // >= rather than == so a live dwell reduction below the current count
      // steps immediately instead of waiting for the counter to wrap.
      assign step_ev = (cnt_r >= dwell);
      assign bad_cfg = (f_min > f_max);

      // A rejected start leaves the channel exactly as it was.
      assign err_req[k] = start[k] && !stop[k] && bad_cfg;

      always_comb begin
         st_n   = st_r;
         freq_n = freq_r;
         cnt_n  = cnt_r;
         done_n = 1'b0;
         if (stop[k]) begin
            st_n = IDLE;
         end else if (start[k]) begin
            if (!bad_cfg) begin
               st_n   = UP;
               freq_n = f_min;
               cnt_n  = '0;
            end
         end else if (sync && run) begin
            st_n   = UP;
            freq_n = f_min;
            cnt_n  = '0;
         end else if (run) begin
            if (mode == M_HOLD) begin
               freq_n = f_min;
               cnt_n  = '0;
            end else if (!step_ev) begin
               cnt_n = cnt_r + DW'(1);
            end else begin
               cnt_n = '0;
               case (mode)
                  M_SAW: begin
                     st_n   = UP;
                     freq_n = over ? f_min : nxt_up[FW-1:0];
                  end
                  M_TRI: begin
                     if (st_r == DOWN) begin
                        if (under) begin
                           freq_n = f_min;
                           st_n   = UP;
                        end else begin
                           freq_n = nxt_dn[FW-1:0];
                        end
                     end else begin
                        if (over) begin
                           freq_n = f_max;
                           st_n   = DOWN;
                        end else begin
                           freq_n = nxt_up[FW-1:0];
                        end
                     end
                  end
                  default: begin
                     // single-shot
                     if (over) begin
                        freq_n = f_max;
                        st_n   = IDLE;
                        done_n = 1'b1;
                     end else begin
                        freq_n = nxt_up[FW-1:0];
                        st_n   = UP;
                     end
                  end
               endcase
            end
         end
      end

      always_ff @(posedge clk) begin
         if (!reset) begin
            st_r   <= IDLE;
            freq_r <= '0;
            cnt_r  <= '0;
            done_r <= 1'b0;
         end else begin
            st_r   <= st_n;
            freq_r <= freq_n;
            cnt_r  <= cnt_n;
            done_r <= done_n;
         end
      end

      assign freq[k*FW +: FW] = freq_r;
      assign active[k]        = run;
      assign done[k]          = done_r;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         cfg_err <= 1'b0;
      end else begin
         cfg_err <= |err_req;
      end
   end

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Directed bench for dds_sweep_ctrl: vector table plus hand sequences.
// A CH=3 copy shares the inputs so that a write with cfg_ch == CH is representable.
// Inputs are driven 1 ns after the rising edge and outputs are checked at the same point.
module tb_dds_sweep_ctrl;

   logic          clk = 1'b0;
   logic          reset;
   logic          cfg_we;
   logic [1:0]    cfg_ch;
   logic [2:0]    cfg_sel;
   logic [31:0]   cfg_data;
   logic [3:0]    start, stop;
   logic          sync;
   logic [127:0]  freq;
   logic [3:0]    active, done;
   logic          cfg_err;
   logic [95:0]   freq3;
   logic [2:0]    active3, done3;
   logic          cfg_err3;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   dds_sweep_ctrl #(.CH(4), .FW(32), .DW(16)) dut (
      .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_sel(cfg_sel),
      .cfg_data(cfg_data), .start(start), .stop(stop), .sync(sync),
      .freq(freq), .active(active), .done(done), .cfg_err(cfg_err)
   );

   dds_sweep_ctrl #(.CH(3), .FW(32), .DW(16)) dut3 (
      .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_sel(cfg_sel),
      .cfg_data(cfg_data), .start(start[2:0]), .stop(stop[2:0]), .sync(sync),
      .freq(freq3), .active(active3), .done(done3), .cfg_err(cfg_err3)
   );

   typedef struct {
      logic        we;
      logic [1:0]  ch;
      logic [2:0]  sel;
      logic [31:0] data;
      logic [3:0]  st;
      logic [3:0]  sp;
      logic        sy;
      int          chk;
      logic [31:0] ef;
      logic [3:0]  ea;
      logic [3:0]  ed;
      logic        ee;
   } vec_t;

   vec_t tbl[16];

   function automatic vec_t mk(logic we, logic [1:0] ch, logic [2:0] sel, logic [31:0] data,
                               logic [3:0] st, logic [3:0] sp, logic sy, int chk,
                               logic [31:0] ef, logic [3:0] ea, logic [3:0] ed, logic ee);
      vec_t v;
      v.we = we; v.ch = ch; v.sel = sel; v.data = data; v.st = st; v.sp = sp; v.sy = sy;
      v.chk = chk; v.ef = ef; v.ea = ea; v.ed = ed; v.ee = ee;
      return v;
   endfunction

   function automatic logic [31:0] fq(int k);
      return freq[k*32 +: 32];
   endfunction

   task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic cyc(input logic we, input logic [1:0] ch, input logic [2:0] sel,
                      input logic [31:0] d, input logic [3:0] st, input logic [3:0] sp,
                      input logic sy);
      cfg_we = we; cfg_ch = ch; cfg_sel = sel; cfg_data = d;
      start = st; stop = sp; sync = sy;
      @(posedge clk);
      #1;
      cfg_we = 1'b0; cfg_ch = '0; cfg_sel = '0; cfg_data = '0;
      start = '0; stop = '0; sync = 1'b0;
   endtask

   task automatic wr(input logic [1:0] ch, input logic [2:0] sel, input logic [31:0] d);
      cyc(1'b1, ch, sel, d, 4'b0, 4'b0, 1'b0);
   endtask

   task automatic idle();
      cyc(1'b0, 2'd0, 3'd0, 32'd0, 4'b0, 4'b0, 1'b0);
   endtask

   int tri_exp[8] = '{0, 4, 8, 10, 6, 2, 0, 4};

   initial begin
      reset = 1'b0;
      cfg_we = 1'b0; cfg_ch = '0; cfg_sel = '0; cfg_data = '0;
      start = '0; stop = '0; sync = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_freq", freq, 128'd0);
      chk("reset_flags", {active, done, cfg_err}, 9'd0);
      reset = 1'b1;

      // ch0 SAW 100..110 step 4, stop, start/stop collision, ch1 rejected start
      tbl[0]  = mk(1, 0, 0, 100, 4'h0, 4'h0, 0, 0, 0,   4'h0, 4'h0, 0);
      tbl[1]  = mk(1, 0, 1, 110, 4'h0, 4'h0, 0, 0, 0,   4'h0, 4'h0, 0);
      tbl[2]  = mk(1, 0, 2, 4,   4'h0, 4'h0, 0, 0, 0,   4'h0, 4'h0, 0);
      tbl[3]  = mk(1, 0, 4, 1,   4'h0, 4'h0, 0, 0, 0,   4'h0, 4'h0, 0);
      tbl[4]  = mk(0, 0, 0, 0,   4'h1, 4'h0, 0, 0, 100, 4'h1, 4'h0, 0);
      tbl[5]  = mk(0, 0, 0, 0,   4'h0, 4'h0, 0, 0, 104, 4'h1, 4'h0, 0);
      tbl[6]  = mk(0, 0, 0, 0,   4'h0, 4'h0, 0, 0, 108, 4'h1, 4'h0, 0);
      tbl[7]  = mk(0, 0, 0, 0,   4'h0, 4'h0, 0, 0, 100, 4'h1, 4'h0, 0);
      tbl[8]  = mk(0, 0, 0, 0,   4'h0, 4'h0, 0, 0, 104, 4'h1, 4'h0, 0);
      tbl[9]  = mk(0, 0, 0, 0,   4'h0, 4'h1, 0, 0, 104, 4'h0, 4'h0, 0);
      tbl[10] = mk(0, 0, 0, 0,   4'h1, 4'h0, 0, 0, 100, 4'h1, 4'h0, 0);
      tbl[11] = mk(0, 0, 0, 0,   4'h1, 4'h1, 0, 0, 100, 4'h0, 4'h0, 0);
      tbl[12] = mk(1, 1, 0, 50,  4'h0, 4'h0, 0, 1, 0,   4'h0, 4'h0, 0);
      tbl[13] = mk(1, 1, 1, 20,  4'h0, 4'h0, 0, 1, 0,   4'h0, 4'h0, 0);
      tbl[14] = mk(0, 0, 0, 0,   4'h2, 4'h0, 0, 1, 0,   4'h0, 4'h0, 1);
      tbl[15] = mk(0, 0, 0, 0,   4'h0, 4'h0, 0, 1, 0,   4'h0, 4'h0, 0);

      for (int i = 0; i < 16; i++) begin
         cyc(tbl[i].we, tbl[i].ch, tbl[i].sel, tbl[i].data, tbl[i].st, tbl[i].sp, tbl[i].sy);
         chk($sformatf("vec%0d_freq", i), fq(tbl[i].chk), tbl[i].ef);
         chk($sformatf("vec%0d_flags", i), {active, done, cfg_err},
             {tbl[i].ea, tbl[i].ed, tbl[i].ee});
      end

      // ch2 TRI 0..10 step 4 dwell 2: each value held three cycles
      wr(2, 1, 10); wr(2, 2, 4); wr(2, 3, 2); wr(2, 4, 2);
      cyc(0, 0, 0, 0, 4'h4, 4'h0, 0);
      for (int i = 0; i < 8; i++) begin
         for (int j = 0; j < 3; j++) begin
            if (i != 0 || j != 0) idle();
            chk($sformatf("tri_%0d_%0d", i, j), fq(2), 32'(tri_exp[i]));
         end
      end
      cyc(0, 0, 0, 0, 4'h0, 4'h4, 0);

      // ch3 SINGLE with carry out of the top bit
      wr(3, 0, 32'hFFFF_FFF0); wr(3, 2, 32'h10); wr(3, 4, 3);
      cyc(0, 0, 0, 0, 4'h8, 4'h0, 0);
      chk("single_start", {fq(3), active[3], done[3]}, {32'hFFFF_FFF0, 1'b1, 1'b0});
      idle();
      chk("single_done", {fq(3), active[3], done[3]}, {32'hFFFF_FFFF, 1'b0, 1'b1});
      idle();
      chk("single_after", {fq(3), active[3], done[3]}, {32'hFFFF_FFFF, 1'b0, 1'b0});
      idle();
      chk("single_hold", {fq(3), active[3], done[3]}, {32'hFFFF_FFFF, 1'b0, 1'b0});

      // ch0 SAW step 4 from 100, ch1 SAW step 7 from 50, then sync
      wr(1, 1, 200); wr(1, 2, 7); wr(1, 4, 1);
      cyc(0, 0, 0, 0, 4'h3, 4'h0, 0);
      chk("sync_pre0", {fq(0), fq(1)}, {32'd100, 32'd50});
      idle();
      chk("sync_pre1", {fq(0), fq(1)}, {32'd104, 32'd57});
      idle();
      chk("sync_pre2", {fq(0), fq(1)}, {32'd108, 32'd64});
      cyc(0, 0, 0, 0, 4'h0, 4'h0, 1);
      chk("sync_hit", {fq(0), fq(1), active}, {32'd100, 32'd50, 4'h3});
      chk("sync_idle_ch3", fq(3), 32'hFFFF_FFFF);
      idle();
      chk("sync_post", {fq(0), fq(1)}, {32'd104, 32'd57});

      // ch2 HOLD at f_min = 5 for 1000 cycles
      wr(2, 0, 5); wr(2, 4, 0);
      cyc(0, 0, 0, 0, 4'h4, 4'h0, 0);
      for (int i = 0; i < 1000; i++) begin
         checks++;
         if (fq(2) !== 32'd5 || active[2] !== 1'b1) begin
            errors++;
            $display("FAIL hold_%0d: got %0h/%b expected 5/1", i, fq(2), active[2]);
         end
         idle();
      end

      // switch ch2 to SAW live, then reset mid-sweep
      wr(2, 4, 1);
      repeat (4) idle();
      chk("pre_reset_active", active, 4'h7);
      reset = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b1;
      chk("midrst_freq", freq, 128'd0);
      chk("midrst_flags", {active, done, cfg_err}, 9'd0);
      cyc(0, 0, 0, 0, 4'hF, 4'h0, 0);
      chk("midrst_start", {freq, active}, {128'd0, 4'hF});
      repeat (3) idle();
      chk("midrst_defaults", {freq, active}, {128'd0, 4'hF});

      // cfg_ch == CH on the CH=3 copy, and a reserved cfg_sel
      wr(3, 0, 77);
      wr(0, 5, 9);
      cyc(0, 0, 0, 0, 4'h0, 4'hF, 0);
      cyc(0, 0, 0, 0, 4'hF, 4'h0, 0);
      chk("ch3_written", fq(3), 32'd77);
      chk("sel5_ignored", fq(0), 32'd0);
      chk("badch_ignored", {freq3, active3}, {96'd0, 3'h7});
      idle();
      chk("sel5_hold", {fq(0), active[0]}, {32'd0, 1'b1});

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/dds_sweep_ctrl.md
# dds_sweep_ctrl

Parametrised N-channel DDS frequency-tuning-word generator that replaces the hard-coded single sweep counter in the AFE top level. Each channel holds its own min/max/step/dwell/mode configuration and produces a frequency word for one `dds_slave` instance. Supported modes are hold, sawtooth wrap, triangle and single-shot. A common `sync` input restarts all running channels phase-coherently.

## Interface
Parameters:
- `CH`, 4, number of channels (1..16)
- `FW`, 32, frequency word width
- `DW`, 16, dwell counter width

Ports:
- `clk`  in  1  DDS-domain clock; all logic on rising edge
- `reset`  in  1  synchronous, active-low reset
- `cfg_we`  in  1  config write strobe
- `cfg_ch`  in  $clog2(CH) (min 1)  target channel
- `cfg_sel`  in  3  0 = f_min, 1 = f_max, 2 = f_step, 3 = dwell, 4 = mode[1:0]; other values are ignored
- `cfg_data`  in  FW  write data, LSB-aligned
- `start`  in  CH  per-channel start pulse
- `stop`  in  CH  per-channel stop pulse
- `sync`  in  1  restart all active channels
- `freq`  out  CH*FW  frequency words; channel k occupies [k*FW +: FW]
- `active`  out  CH  channel running
- `done`  out  CH  one-cycle pulse at single-shot completion
- `cfg_err`  out  1  one-cycle pulse when a start is rejected

## Operation
- Config register reset values: f_min = 0, f_max = all ones, f_step = 1, dwell = 0, mode = 0.
- Writes take effect on the next cycle. A write to a running channel is used live from the next step evaluation onward.
- A write with `cfg_ch` ≥ CH is ignored.
- Per-channel FSM states: IDLE, UP, DOWN.
- Transitions out of IDLE:
  - A start with f_min ≤ f_max → UP, with freq = f_min and the dwell counter cleared.
  - A start with f_min > f_max → stay in IDLE, pulse `cfg_err`.
- Step event: the dwell counter reaches `dwell`. It then clears, and the mode rule below is applied. dwell = 0 gives a step every cycle.
- Arithmetic is done in FW+1 bits. In UP, nxt = freq + f_step. In DOWN, nxt = freq − f_step. "Over" means nxt > f_max or carry out. "Under" means nxt < f_min or borrow.
- Mode 0, HOLD: freq stays at f_min and no steps are taken. The channel remains active until stopped.
- Mode 1, SAW: over → freq = f_min; otherwise freq = nxt.
- Mode 2, TRI:
  - In UP: over → freq = f_max, go to DOWN.
  - In DOWN: under → freq = f_min, go to UP.
- Mode 3, SINGLE: over → freq = f_max, `done` pulses, go to IDLE.
- f_step = 0 in modes 1–3 leaves freq constant. The channel never completes and this is legal.
- `stop` → IDLE. freq holds its last value and `done` does not pulse.
- Start on an active channel restarts it at f_min and UP.
- Same-cycle stop and start → stop wins.
- `sync` forces every active channel to freq = f_min, UP, dwell counter 0. Idle channels are unaffected.
- `sync` together with a start on the same channel behaves as a start.

## Timing
- Reset (`reset` = 0 at a clock edge): freq = 0, active = 0, done = 0, cfg_err = 0, all FSMs IDLE, config registers at defaults. Reset overrides every other input, including during a sweep.
- Start sampled at edge t → active = 1 and freq = f_min visible after edge t+1.
- First step lands at edge t+1+(dwell+1). Steps then repeat every dwell+1 cycles.
- `done` is high for exactly one cycle, aligned with the cycle where freq = f_max and active falls.
- `cfg_err` is high for one cycle, the cycle after the rejected start.
- `sync` sampled at edge t → all active channels show f_min after edge t+1, so restarts are cycle-aligned across channels.
- Each output is registered; no combinational path from input to output.

## Test plan
- Reset mid-sweep: CH=4, channel 2 running SAW, drop `reset` for 1 cycle → all freq = 0, active = 0 on the next cycle, and config is back to defaults.
- SAW wrap: f_min=100, f_max=110, step=4, dwell=0 → freq sequence 100, 104, 108, 100, 104…
- TRI with dwell: f_min=0, f_max=10, step=4, dwell=2 → 0, 4, 8, 10, 6, 2, 0, 4…, each value held for 3 cycles.
- SINGLE with overflow: f_min=0xFFFFFFF0, f_max=all ones, step=0x10 → freq goes to 0xFFFFFFFF, `done` pulses once, active = 0, and freq holds.
- Invalid config and sync:
  - f_min=50, f_max=20, start → `cfg_err` pulse, active stays 0.
  - Channels 0 and 1 running SAW with different steps, assert `sync` → both show f_min on the same cycle.
- Control collisions:
  - stop and start on the same cycle → IDLE.
  - `cfg_ch` = CH write → no config change.
  - HOLD mode → freq constant at f_min for 1000 cycles.
